// File: rtl/ace_video_fetch_if.sv
// Bundles the read-only RAM ports and the serial video outputs of the fetch engine.
// The master side is the fetch engine; the slave side is the RAMs plus the video output stage.
interface ace_video_fetch_if;
    logic [9:0] scr_addr;
    logic [7:0] scr_data;
    logic [9:0] chr_addr;
    logic [7:0] chr_data;
    logic       pixel;
    logic       blank;
    logic       hsync_n;
    logic       vsync_n;
    logic       vint;
    logic       vid_busy;

    modport master (
        output scr_addr, chr_addr, pixel, blank, hsync_n, vsync_n, vint, vid_busy,
        input  scr_data, chr_data
    );

    modport slave (
        input  scr_addr, chr_addr, pixel, blank, hsync_n, vsync_n, vint, vid_busy,
        output scr_data, chr_data
    );
endinterface

// File: rtl/ace_video_fetch.sv
// Read-side video engine: H/V timing, screen/char RAM fetch and pixel serialiser
// for a 256x192 mono picture built from 32x24 cells, with bit 7 of the code giving inverse video.
module ace_video_fetch #(
    parameter int H_TOTAL  = 416,
    parameter int V_TOTAL  = 312,
    parameter int HS_START = 320,
    parameter int HS_LEN   = 32,
    parameter int VS_START = 248,
    parameter int VS_LEN   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic ce_pix,
    ace_video_fetch_if.master vbus
);

    localparam logic [8:0] H_LAST   = 9'(H_TOTAL - 1);
    localparam logic [8:0] V_LAST   = 9'(V_TOTAL - 1);
    localparam logic [8:0] HS_FIRST = 9'(HS_START);
    localparam logic [8:0] HS_END   = 9'(HS_START + HS_LEN);
    localparam logic [8:0] VS_FIRST = 9'(VS_START);
    localparam logic [8:0] VS_END   = 9'(VS_START + VS_LEN);

    logic [8:0] hc;
    logic [8:0] vc;
    logic [7:0] code;
    logic [7:0] pattern;
    logic [7:0] shreg;
    logic       active;
    logic       fetch;
    logic       loadSlot;

    always_comb begin
        active   = (hc >= 9'd8) && (hc < 9'd264) && (vc < 9'd192);
        fetch    = (hc < 9'd256) && (vc < 9'd192);
        loadSlot = active && (hc[2:0] == 3'd0);
    end

    // Column c is fetched during hc 8c..8c+7 and shown at 8c+8..8c+15, so every
    // output registered on a tick describes the position hc held on that tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            hc             <= '0;
            vc             <= '0;
            code           <= '0;
            pattern        <= '0;
            shreg          <= '0;
            vbus.scr_addr  <= '0;
            vbus.chr_addr  <= '0;
            vbus.pixel     <= 1'b0;
            vbus.blank     <= 1'b1;
            vbus.hsync_n   <= 1'b1;
            vbus.vsync_n   <= 1'b1;
            vbus.vint      <= 1'b0;
            vbus.vid_busy  <= 1'b0;
        end else if (ce_pix) begin
            if (hc == H_LAST) begin
                hc <= '0;
                vc <= (vc == V_LAST) ? 9'd0 : vc + 9'd1;
            end else begin
                hc <= hc + 9'd1;
            end

            if (fetch) begin
                case (hc[2:0])
                    3'd0: vbus.scr_addr <= {vc[7:3], hc[7:3]};
                    3'd2: begin
                        code          <= vbus.scr_data;
                        vbus.chr_addr <= {vbus.scr_data[6:0], vc[2:0]};
                    end
                    3'd4: pattern <= vbus.chr_data ^ {8{code[7]}};
                    default: ;
                endcase
            end

            if (loadSlot) begin
                shreg      <= pattern;
                vbus.pixel <= pattern[7];
            end else begin
                shreg      <= {shreg[6:0], 1'b0};
                vbus.pixel <= active && shreg[6];
            end

            vbus.blank    <= !active;
            vbus.hsync_n  <= !((hc >= HS_FIRST) && (hc < HS_END));
            vbus.vsync_n  <= !((vc >= VS_FIRST) && (vc < VS_END));
            vbus.vint     <= (hc == 9'd0) && (vc == VS_FIRST);
            vbus.vid_busy <= (vc < 9'd192) && (hc < 9'd264);
        end else begin
            vbus.vint <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ace_video_fetch.sv
// Self-checking bench for ace_video_fetch; uses a shortened frame so a full frame
// plus the wrap into the next one fits in a short run.
module tb_ace_video_fetch;

    localparam int H   = 288;
    localparam int V   = 200;
    localparam int HSS = 272;
    localparam int HSL = 8;
    localparam int VSS = 194;
    localparam int VSL = 3;

    typedef struct {
        int   v;
        int   h;
        logic pix;
        logic blk;
        logic hsn;
        logic vsn;
        logic busy;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ce  = 1'b0;

    ace_video_fetch_if vbus ();

    ace_video_fetch #(
        .H_TOTAL (H),
        .V_TOTAL (V),
        .HS_START(HSS),
        .HS_LEN  (HSL),
        .VS_START(VSS),
        .VS_LEN  (VSL)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .ce_pix(ce),
        .vbus  (vbus)
    );

    always #5 clk = ~clk;

    logic [7:0] scrMem [1024];
    logic [7:0] chrMem [1024];

    always @(posedge clk) begin
        vbus.scr_data <= scrMem[vbus.scr_addr];
        vbus.chr_data <= chrMem[vbus.chr_addr];
    end

    int passCount  = 0;
    int checkCount = 0;
    int curH, curV, nextH, nextV;
    int frozenErr  = 0;
    vec_t tbl[$];

    function automatic logic expActive(int h, int v);
        return (h >= 8) && (h < 264) && (v < 192);
    endfunction

    // Behavioural picture model: which ink bit belongs at (h, v), straight from RAM contents.
    function automatic logic expPixel(int h, int v);
        int col, b;
        logic [7:0] cd, pat;
        logic [9:0] ci;
        if (!expActive(h, v)) return 1'b0;
        col = (h - 8) / 8;
        b   = (h - 8) % 8;
        cd  = scrMem[(v / 8) * 32 + col];
        ci  = {cd[6:0], 3'(v % 8)};
        pat = chrMem[ci] ^ {8{cd[7]}};
        return pat[7 - b];
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // One pixel tick, then 'gap' clocks with ce_pix low during which nothing may move.
    task automatic applyStimulus(input int gap);
        logic [25:0] snap;
        ce = 1'b1;
        @(posedge clk);
        #1;
        curH = nextH;
        curV = nextV;
        nextH++;
        if (nextH == H) begin
            nextH = 0;
            nextV = (nextV == V - 1) ? 0 : nextV + 1;
        end
        snap = {vbus.pixel, vbus.blank, vbus.hsync_n, vbus.vsync_n, vbus.vid_busy,
                vbus.scr_addr, vbus.chr_addr, 1'b0};
        if (gap > 0) begin
            ce = 1'b0;
            repeat (gap) begin
                @(posedge clk);
                #1;
                if ({vbus.pixel, vbus.blank, vbus.hsync_n, vbus.vsync_n, vbus.vid_busy,
                     vbus.scr_addr, vbus.chr_addr, vbus.vint} != snap)
                    frozenErr++;
            end
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        ce  = 1'b0;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        nextH = 0;
        nextV = 0;
    endtask

    function automatic void addVec(int v, int h, logic p, logic b, logic hs, logic vs, logic bz);
        vec_t e;
        e.v = v; e.h = h; e.pix = p; e.blk = b; e.hsn = hs; e.vsn = vs; e.busy = bz;
        tbl.push_back(e);
    endfunction

    initial begin
        int ti, pixErr, blkErr, hsErr, vsErr, busyErr, vintErr, vintCount, hsLow, vsLines, addrErr, thrErr;
        logic [7:0] invPat;

        for (int i = 0; i < 1024; i++) begin
            scrMem[i] = 8'h00;
            chrMem[i] = 8'h00;
        end
        scrMem[0]     = 8'h01;
        scrMem[1]     = 8'h02;
        scrMem[32]    = 8'h83;
        chrMem[10'h008] = 8'hA5;
        chrMem[10'h010] = 8'h3C;
        chrMem[10'h019] = 8'h0F;

        //      v    h   pix blk hsn vsn busy
        addVec(0,   0,   0,  1,  1,  1,  1);
        addVec(0,   7,   0,  1,  1,  1,  1);
        addVec(0,   8,   1,  0,  1,  1,  1);
        addVec(0,   9,   0,  0,  1,  1,  1);
        addVec(0,   10,  1,  0,  1,  1,  1);
        addVec(0,   11,  0,  0,  1,  1,  1);
        addVec(0,   12,  0,  0,  1,  1,  1);
        addVec(0,   13,  1,  0,  1,  1,  1);
        addVec(0,   14,  0,  0,  1,  1,  1);
        addVec(0,   15,  1,  0,  1,  1,  1);
        addVec(0,   16,  0,  0,  1,  1,  1);
        addVec(0,   18,  1,  0,  1,  1,  1);
        addVec(0,   21,  1,  0,  1,  1,  1);
        addVec(0,   22,  0,  0,  1,  1,  1);
        addVec(0,   263, 0,  0,  1,  1,  1);
        addVec(0,   264, 0,  1,  1,  1,  0);
        addVec(0,   271, 0,  1,  1,  1,  0);
        addVec(0,   272, 0,  1,  0,  1,  0);
        addVec(0,   279, 0,  1,  0,  1,  0);
        addVec(0,   280, 0,  1,  1,  1,  0);
        addVec(9,   8,   1,  0,  1,  1,  1);
        addVec(9,   11,  1,  0,  1,  1,  1);
        addVec(9,   12,  0,  0,  1,  1,  1);
        addVec(9,   16,  0,  0,  1,  1,  1);
        addVec(191, 263, 0,  0,  1,  1,  1);
        addVec(192, 8,   0,  1,  1,  1,  0);
        addVec(193, 287, 0,  1,  1,  1,  0);
        addVec(194, 0,   0,  1,  1,  0,  0);
        addVec(196, 287, 0,  1,  1,  0,  0);
        addVec(197, 0,   0,  1,  1,  1,  0);

        repeat (3) @(posedge clk);
        #1;
        doReset();

        // Reset asserted mid-line with ce_pix high must win on the very next edge.
        do applyStimulus(0); while (curH != 40);
        rst = 1'b1;
        ce  = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("reset blank",    vbus.blank,    1);
        checkOutput("reset hsync_n",  vbus.hsync_n,  1);
        checkOutput("reset vsync_n",  vbus.vsync_n,  1);
        checkOutput("reset pixel",    vbus.pixel,    0);
        checkOutput("reset vint",     vbus.vint,     0);
        checkOutput("reset vid_busy", vbus.vid_busy, 0);
        checkOutput("reset scr_addr", vbus.scr_addr, 0);
        checkOutput("reset chr_addr", vbus.chr_addr, 0);
        rst   = 1'b0;
        ce    = 1'b0;
        nextH = 0;
        nextV = 0;

        // Full-speed frame plus the start of the next one, against the picture/timing model.
        ti = 0; pixErr = 0; blkErr = 0; hsErr = 0; vsErr = 0; busyErr = 0; vintErr = 0;
        vintCount = 0; hsLow = 0; vsLines = 0; addrErr = 0;
        for (int n = 0; n < H * V + 300; n++) begin
            applyStimulus(0);
            if (vbus.pixel != expPixel(curH, curV)) pixErr++;
            if (vbus.blank != !expActive(curH, curV)) blkErr++;
            if (vbus.hsync_n != !(curH >= HSS && curH < HSS + HSL)) hsErr++;
            if (vbus.vsync_n != !(curV >= VSS && curV < VSS + VSL)) vsErr++;
            if (vbus.vid_busy != (curV < 192 && curH < 264)) busyErr++;
            if (vbus.vint != (curH == 0 && curV == VSS)) vintErr++;
            if (vbus.vint) vintCount++;
            if (curV == 0 && n < H && !vbus.hsync_n) hsLow++;
            if (curH == 0 && !vbus.vsync_n) vsLines++;
            if (curV == 9) begin
                if (curH % 8 == 1 && curH < 256 && vbus.scr_addr != 10'(32 + curH / 8)) addrErr++;
                if (curH >= 2 && vbus.chr_addr[2:0] != 3'd1) addrErr++;
                if (curH % 8 == 3 && curH < 256 &&
                    vbus.chr_addr != {scrMem[32 + curH / 8][6:0], 3'd1}) addrErr++;
                if (curH == H - 1) checkOutput("line9 scr_addr hold", vbus.scr_addr, 10'h03F);
            end
            if (curV == 191 && curH == 249) checkOutput("scr_addr max", vbus.scr_addr, 767);
            if (ti < tbl.size() && curV == tbl[ti].v && curH == tbl[ti].h) begin
                checkOutput($sformatf("v%0d h%0d pixel",   curV, curH), vbus.pixel,    tbl[ti].pix);
                checkOutput($sformatf("v%0d h%0d blank",   curV, curH), vbus.blank,    tbl[ti].blk);
                checkOutput($sformatf("v%0d h%0d hsync_n", curV, curH), vbus.hsync_n,  tbl[ti].hsn);
                checkOutput($sformatf("v%0d h%0d vsync_n", curV, curH), vbus.vsync_n,  tbl[ti].vsn);
                checkOutput($sformatf("v%0d h%0d busy",    curV, curH), vbus.vid_busy, tbl[ti].busy);
                ti++;
            end
        end
        checkOutput("table vectors reached", ti, tbl.size());
        checkOutput("frame pixel errors",    pixErr,    0);
        checkOutput("frame blank errors",    blkErr,    0);
        checkOutput("frame hsync errors",    hsErr,     0);
        checkOutput("frame vsync errors",    vsErr,     0);
        checkOutput("frame busy errors",     busyErr,   0);
        checkOutput("frame vint errors",     vintErr,   0);
        checkOutput("vint pulses per frame", vintCount, 1);
        checkOutput("hsync low ticks",       hsLow,     HSL);
        checkOutput("vsync low lines",       vsLines,   VSL);
        checkOutput("line9 address errors",  addrErr,   0);

        // Inverse video: code 0x81 uses the same glyph with every bit flipped.
        doReset();
        scrMem[0] = 8'h81;
        invPat    = 8'h5A;
        do applyStimulus(0); while (curH != 7);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0);
            checkOutput($sformatf("inverse h%0d", curH), vbus.pixel, invPat[7 - i]);
        end

        // Throttled pixel clock: one tick in three must give the same picture per tick.
        doReset();
        scrMem[0] = 8'h01;
        thrErr    = 0;
        frozenErr = 0;
        for (int n = 0; n < 2 * H; n++) begin
            applyStimulus(2);
            if (vbus.pixel != expPixel(curH, curV)) thrErr++;
            if (vbus.blank != !expActive(curH, curV)) thrErr++;
        end
        checkOutput("throttle picture errors", thrErr,    0);
        checkOutput("ce low frozen errors",    frozenErr, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
